uart_rx_ctrl: RTL and testbench

Receive-side sequencer for the UART. It oversamples the RX line from a baud-rate tick, detects and qualifies the start bit, and shifts in data bits at their midpoints. It checks optional parity, then issues a one-cycle chk_stop strobe with the line sample, which drives the stop-bit checker. It presents the assembled byte with a valid pulse and per-frame error flags to the host side.

---
 rtl/uart_rx_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: synchronizes the RX line, qualifies the start bit,
// samples data/parity/stop at bit midpoints on baud_tick, and reports the
// assembled word with a one-clock valid pulse and per-frame error flags.
module uart_rx_ctrl #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 baud_tick,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 chk_stop,
    output logic                 stop_sample,
    output logic                 parity_error,
    output logic                 framing_error,
    output logic                 busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] TICK_ZERO = TW'(0);
    localparam logic [TW-1:0] TICK_ONE  = TW'(1);
    localparam logic [BW-1:0] BIT_ZERO  = BW'(0);
    localparam logic [BW-1:0] BIT_ONE   = BW'(1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    // Nonzero when the data word plus received parity bit violate the
    // configured parity sense.
    function automatic logic calc_par_bad(input logic [DATA_BITS-1:0] d,
                                          input logic                 p);
        calc_par_bad = (^d) ^ p ^ (PARITY_ODD != 0);
    endfunction

    logic [1:0]           sync_r;
    logic                 rx_s;
    state_t               state_r, state_s;
    logic [TW-1:0]        tick_cnt_r, tick_cnt_s;
    logic [BW-1:0]        bit_idx_r, bit_idx_s;
    logic [DATA_BITS-1:0] shift_r, shift_s;
    logic                 par_bad_r, par_bad_s;
    logic [DATA_BITS-1:0] rx_data_r, rx_data_s;
    logic                 rx_valid_r, rx_valid_s;
    logic                 chk_stop_r, chk_stop_s;
    logic                 stop_sample_r, stop_sample_s;
    logic                 parity_error_r, parity_error_s;
    logic                 framing_error_r, framing_error_s;
    logic                 busy_r;

    assign rx_s = sync_r[1];

    // Two-flop synchronizer for the asynchronous RX line (idles high).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_r <= 2'b11;
        end else begin
            sync_r <= {sync_r[0], rx_in};
        end
    end

    // State, counters, datapath and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r         <= IDLE;
            tick_cnt_r      <= TICK_ZERO;
            bit_idx_r       <= BIT_ZERO;
            shift_r         <= '0;
            par_bad_r       <= 1'b0;
            rx_data_r       <= '0;
            rx_valid_r      <= 1'b0;
            chk_stop_r      <= 1'b0;
            stop_sample_r   <= 1'b0;
            parity_error_r  <= 1'b0;
            framing_error_r <= 1'b0;
            busy_r          <= 1'b0;
        end else begin
            state_r         <= state_s;
            tick_cnt_r      <= tick_cnt_s;
            bit_idx_r       <= bit_idx_s;
            shift_r         <= shift_s;
            par_bad_r       <= par_bad_s;
            rx_data_r       <= rx_data_s;
            rx_valid_r      <= rx_valid_s;
            chk_stop_r      <= chk_stop_s;
            stop_sample_r   <= stop_sample_s;
            parity_error_r  <= parity_error_s;
            framing_error_r <= framing_error_s;
            busy_r          <= (state_s != IDLE);
        end
    end

    // Next-state and datapath logic; everything advances only on baud_tick.
    always_comb begin
        state_s         = state_r;
        tick_cnt_s      = tick_cnt_r;
        bit_idx_s       = bit_idx_r;
        shift_s         = shift_r;
        par_bad_s       = par_bad_r;
        rx_data_s       = rx_data_r;
        rx_valid_s      = 1'b0;
        chk_stop_s      = 1'b0;
        stop_sample_s   = stop_sample_r;
        parity_error_s  = parity_error_r;
        framing_error_s = framing_error_r;
        if (baud_tick) begin
            case (state_r)
                IDLE: begin
                    if (!rx_s) begin
                        state_s    = START;
                        tick_cnt_s = TICK_ZERO;
                    end else begin
                        state_s = IDLE;
                    end
                end
                START: begin
                    if (tick_cnt_r == TICK_HALF) begin
                        tick_cnt_s = TICK_ZERO;
                        bit_idx_s  = BIT_ZERO;
                        // A start bit that is high again at its midpoint is a glitch.
                        if (!rx_s) begin
                            state_s = DATA;
                        end else begin
                            state_s = IDLE;
                        end
                    end else begin
                        tick_cnt_s = tick_cnt_r + TICK_ONE;
                    end
                end
                DATA: begin
                    if (tick_cnt_r == TICK_LAST) begin
                        shift_s    = {rx_s, shift_r[DATA_BITS-1:1]};
                        tick_cnt_s = TICK_ZERO;
                        bit_idx_s  = bit_idx_r + BIT_ONE;
                        if (bit_idx_r == BIT_LAST) begin
                            state_s = (PARITY_EN != 0) ? PARITY : STOP;
                        end else begin
                            state_s = DATA;
                        end
                    end else begin
                        tick_cnt_s = tick_cnt_r + TICK_ONE;
                    end
                end
                PARITY: begin
                    if (tick_cnt_r == TICK_LAST) begin
                        par_bad_s  = calc_par_bad(shift_r, rx_s);
                        state_s    = STOP;
                        tick_cnt_s = TICK_ZERO;
                    end else begin
                        tick_cnt_s = tick_cnt_r + TICK_ONE;
                    end
                end
                STOP: begin
                    if (tick_cnt_r == TICK_LAST) begin
                        chk_stop_s      = 1'b1;
                        stop_sample_s   = rx_s;
                        framing_error_s = ~rx_s;
                        parity_error_s  = (PARITY_EN != 0) ? par_bad_r : 1'b0;
                        rx_data_s       = shift_r;
                        rx_valid_s      = 1'b1;
                        state_s         = IDLE;
                        tick_cnt_s      = TICK_ZERO;
                    end else begin
                        tick_cnt_s = tick_cnt_r + TICK_ONE;
                    end
                end
                default: begin
                    state_s    = IDLE;
                    tick_cnt_s = TICK_ZERO;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    assign rx_data       = rx_data_r;
    assign rx_valid      = rx_valid_r;
    assign chk_stop      = chk_stop_r;
    assign stop_sample   = stop_sample_r;
    assign parity_error  = parity_error_r;
    assign framing_error = framing_error_r;
    assign busy          = busy_r;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: frames are serialized onto rx_in,
// the expected word/flags are queued when a frame is sent and compared when
// the DUT pulses rx_valid.
module tb_uart_rx_ctrl;

    localparam int DATA_BITS  = 8;
    localparam int OVERSAMPLE = 16;
    localparam int PARITY_EN  = 1;
    localparam int PARITY_ODD = 0;
    localparam int TICK_DIV   = 4;

    typedef struct packed {
        logic [7:0] data;
        logic       pe;
        logic       fe;
        logic       ss;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       baud_tick = 1'b0;
    logic       rx_in = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid, chk_stop, stop_sample, parity_error, framing_error, busy;

    int   checks = 0;
    int   errors = 0;
    int   valid_cnt = 0;
    int   chk_cnt = 0;
    int   div = 0;
    exp_t exp_q[$];
    exp_t last_exp;

    uart_rx_ctrl #(
        .DATA_BITS(DATA_BITS), .OVERSAMPLE(OVERSAMPLE),
        .PARITY_EN(PARITY_EN), .PARITY_ODD(PARITY_ODD)
    ) dut (
        .clk(clk), .reset_n(reset_n), .baud_tick(baud_tick), .rx_in(rx_in),
        .rx_data(rx_data), .rx_valid(rx_valid), .chk_stop(chk_stop),
        .stop_sample(stop_sample), .parity_error(parity_error),
        .framing_error(framing_error), .busy(busy)
    );

    always #5 clk = ~clk;

    // Baud tick generator: one-clk pulse every TICK_DIV clocks, changed on negedge.
    always @(negedge clk) begin
        if (div == TICK_DIV - 1) begin
            div = 0;
            baud_tick = 1'b1;
        end else begin
            div = div + 1;
            baud_tick = 1'b0;
        end
    end

    // Scoreboard monitor: pop and compare on every rx_valid.
    always @(negedge clk) begin
        exp_t e;
        if (rx_valid === 1'b1 || chk_stop === 1'b1) begin
            checks++;
            if (chk_stop !== rx_valid) begin
                errors++;
                $display("FAIL strobe_align chk_stop=%b rx_valid=%b required equal", chk_stop, rx_valid);
            end
        end
        if (chk_stop === 1'b1) chk_cnt++;
        if (rx_valid === 1'b1) begin
            valid_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid rx_data=%h required no rx_valid", rx_data);
            end else begin
                e = exp_q.pop_front();
                if ({rx_data, parity_error, framing_error, stop_sample} !== {e.data, e.pe, e.fe, e.ss}) begin
                    errors++;
                    $display("FAIL frame data=%h pe=%b fe=%b ss=%b required data=%h pe=%b fe=%b ss=%b",
                             rx_data, parity_error, framing_error, stop_sample, e.data, e.pe, e.fe, e.ss);
                end
            end
        end
    end

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            while (baud_tick !== 1'b1) @(posedge clk);
        end
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stp);
        exp_t e;
        e.data = d;
        e.pe   = (^d) ^ par ^ (PARITY_ODD != 0);
        e.fe   = ~stp;
        e.ss   = stp;
        exp_q.push_back(e);
        last_exp = e;
        rx_in = 1'b0;
        wait_ticks(OVERSAMPLE);
        for (int i = 0; i < 8; i++) begin
            rx_in = d[i];
            wait_ticks(OVERSAMPLE);
        end
        rx_in = par;
        wait_ticks(OVERSAMPLE);
        rx_in = stp;
        wait_ticks(OVERSAMPLE);
        rx_in = 1'b1;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout pending=%0d required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({rx_data, rx_valid, chk_stop, stop_sample, parity_error, framing_error, busy} !== 14'h0) begin
            errors++;
            $display("FAIL reset_state outputs=%h required 0",
                     {rx_data, rx_valid, chk_stop, stop_sample, parity_error, framing_error, busy});
        end
        repeat (5) @(negedge clk);
        reset_n = 1'b1;
        wait_ticks(10);
    endtask

    task automatic test_default();
        int v0 = valid_cnt;
        int c0 = chk_cnt;
        send_frame(8'hA5, 1'b0, 1'b1);
        wait_drain("default");
        wait_ticks(20);
        checks++;
        if (valid_cnt - v0 != 1 || chk_cnt - c0 != 1) begin
            errors++;
            $display("FAIL default_pulses valid=%0d chk=%0d required 1 1", valid_cnt - v0, chk_cnt - c0);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL default_busy busy=%b required 0", busy);
        end
    endtask

    task automatic test_parity();
        send_frame(8'h01, 1'b0, 1'b1);
        wait_drain("parity_bad");
        wait_ticks(20);
        checks++;
        if (parity_error !== 1'b1) begin
            errors++;
            $display("FAIL parity_hold parity_error=%b required 1", parity_error);
        end
        send_frame(8'h03, 1'b0, 1'b1);
        wait_drain("parity_clear");
        wait_ticks(20);
    endtask

    task automatic test_framing();
        send_frame(8'h3C, 1'b0, 1'b0);
        wait_drain("framing_bad");
        wait_ticks(24);
        checks++;
        if (framing_error !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL framing_hold fe=%b busy=%b required 1 0", framing_error, busy);
        end
        send_frame(8'h3C, 1'b0, 1'b1);
        wait_drain("framing_clear");
        wait_ticks(20);
    endtask

    task automatic test_glitch();
        int v0 = valid_cnt;
        int c0 = chk_cnt;
        rx_in = 1'b0;
        wait_ticks(3);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL glitch_busy busy=%b required 1", busy);
        end
        wait_ticks(1);
        rx_in = 1'b1;
        wait_ticks(30);
        checks++;
        if (busy !== 1'b0 || valid_cnt != v0 || chk_cnt != c0) begin
            errors++;
            $display("FAIL glitch_idle busy=%b valids=%0d chks=%0d required 0 0 0",
                     busy, valid_cnt - v0, chk_cnt - c0);
        end
        checks++;
        if ({rx_data, parity_error, framing_error} !== {last_exp.data, last_exp.pe, last_exp.fe}) begin
            errors++;
            $display("FAIL glitch_flags data=%h pe=%b fe=%b required data=%h pe=%b fe=%b",
                     rx_data, parity_error, framing_error, last_exp.data, last_exp.pe, last_exp.fe);
        end
    endtask

    task automatic test_back_to_back();
        int v0 = valid_cnt;
        send_frame(8'h55, 1'b0, 1'b1);
        send_frame(8'hFF, 1'b0, 1'b1);
        wait_drain("b2b");
        wait_ticks(20);
        checks++;
        if (valid_cnt - v0 != 2) begin
            errors++;
            $display("FAIL b2b_count valids=%0d required 2", valid_cnt - v0);
        end
    endtask

    task automatic test_reset_midframe();
        int v0;
        rx_in = 1'b0;
        wait_ticks(OVERSAMPLE);
        rx_in = 1'b1;
        wait_ticks(4 * OVERSAMPLE + OVERSAMPLE / 2);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL midframe_busy busy=%b required 1", busy);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({rx_data, rx_valid, chk_stop, stop_sample, parity_error, framing_error, busy} !== 14'h0) begin
            errors++;
            $display("FAIL midframe_reset outputs=%h required 0",
                     {rx_data, rx_valid, chk_stop, stop_sample, parity_error, framing_error, busy});
        end
        v0 = valid_cnt;
        repeat (6) @(negedge clk);
        reset_n = 1'b1;
        wait_ticks(5 * OVERSAMPLE);
        checks++;
        if (valid_cnt != v0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midframe_abort valids=%0d busy=%b required 0 0", valid_cnt - v0, busy);
        end
        send_frame(8'h81, 1'b0, 1'b1);
        wait_drain("after_reset");
        wait_ticks(20);
    endtask

    initial begin
        test_reset();
        test_default();
        test_parity();
        test_framing();
        test_glitch();
        test_back_to_back();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
